// File: rtl/hc191_counter.sv
// hc191_counter: presettable synchronous up/down binary counter with terminal-count
// and ripple-carry outputs, cascadable by chaining RCN into the next stage's CEN.
//   CP   - clock, all state changes on its rising edge (except reset)
//   MRN  - asynchronous master reset, active-low, forces Q to zero
//   PLN  - synchronous parallel load, active-low, highest priority on an edge
//   CEN  - count enable, active-low
//   UD   - count direction, 0 = up, 1 = down
//   D    - parallel load data
//   Q    - registered counter state
//   TC   - terminal count, high at all-ones counting up or zero counting down
//   RCN  - ripple-carry enable for the next stage, active-low
module hc191_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             MRN,
    input  logic             PLN,
    input  logic             CEN,
    input  logic             UD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             RCN
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge CP or negedge MRN)
        if (!MRN)
            Q <= '0;
        else if (!PLN)
            Q <= D;
        else if (!CEN)
            Q <= UD ? Q - ONE : Q + ONE;

    // TC depends on the live UD, so a direction change is reflected before the edge.
    always_comb begin
        TC  = UD ? (Q == '0) : (&Q);
        RCN = ~(TC & ~CEN);
    end
endmodule

// File: tb/tb_hc191_counter.sv
module tb_hc191_counter;
    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       rcn;
    } exp_t;

    logic       CP = 1'b0;
    logic       MRN, PLN, CEN, UD;
    logic [3:0] D;
    logic [3:0] Q0, Q1;
    logic       TC0, RCN0, TC1, RCN1;

    exp_t       sb[$];
    logic [3:0] m;
    int         total = 0;
    int         bad = 0;

    hc191_counter #(.WIDTH(4)) dut0 (
        .CP(CP), .MRN(MRN), .PLN(PLN), .CEN(CEN), .UD(UD), .D(D),
        .Q(Q0), .TC(TC0), .RCN(RCN0)
    );

    hc191_counter #(.WIDTH(4)) dut1 (
        .CP(CP), .MRN(MRN), .PLN(PLN), .CEN(RCN0), .UD(UD), .D(D),
        .Q(Q1), .TC(TC1), .RCN(RCN1)
    );

    always #5 CP = ~CP;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Applies one edge of stimulus and queues the model's expected post-edge outputs.
    task automatic drive(input logic pln, input logic cen, input logic ud, input logic [3:0] d);
        exp_t e;
        @(negedge CP);
        PLN = pln; CEN = cen; UD = ud; D = d;
        m = !pln ? d : !cen ? (ud ? m - 4'd1 : m + 4'd1) : m;
        e.q   = m;
        e.tc  = ud ? (m == 4'd0) : (m == 4'd15);
        e.rcn = !(e.tc && !cen);
        sb.push_back(e);
        @(posedge CP);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        MRN = 1'b0; PLN = 1'bx; CEN = 1'bx; UD = 1'b0; D = 4'bx;
        #3;
        total++;
        if ({Q0, TC0, RCN0} !== {4'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_initial: got q=%h tc=%b rcn=%b want q=0 tc=0 rcn=1", Q0, TC0, RCN0);
        end
        repeat (2) @(posedge CP);
        #1;
        UD = 1'b1; CEN = 1'b0;
        #1;
        total++;
        if ({Q0, TC0, RCN0} !== {4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold_down: got q=%h tc=%b rcn=%b want q=0 tc=1 rcn=0", Q0, TC0, RCN0);
        end
        @(negedge CP);
        PLN = 1'b1; CEN = 1'b1; UD = 1'b0; D = 4'd0;
        MRN = 1'b1; m = 4'd0;
        #1;
        total++;
        if (Q0 !== 4'd0) begin
            bad++;
            $display("FAIL reset_release: got q=%h want q=0", Q0);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd5);
        e = sb.pop_front();
        total++;
        if ({Q0, TC0, RCN0} !== {e.q, e.tc, e.rcn}) begin
            bad++;
            $display("FAIL reset_load5: got q=%h tc=%b rcn=%b want q=%h tc=%b rcn=%b", Q0, TC0, RCN0, e.q, e.tc, e.rcn);
        end
        #1 MRN = 1'b0;
        #1;
        total++;
        if ({Q0, TC0} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_async: got q=%h tc=%b want q=0 tc=0", Q0, TC0);
        end
        MRN = 1'b1; m = 4'd0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0);
            e = sb.pop_front();
            total++;
            if ({Q0, TC0, RCN0} !== {e.q, e.tc, e.rcn}) begin
                bad++;
                $display("FAIL reset_count%0d: got q=%h tc=%b rcn=%b want q=%h tc=%b rcn=%b", i, Q0, TC0, RCN0, e.q, e.tc, e.rcn);
            end
        end
        total++;
        if (Q0 !== 4'd3) begin
            bad++;
            $display("FAIL reset_count_final: got q=%h want q=3", Q0);
        end
    endtask

    task automatic test_up_wrap;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 1'b0, 4'd14);
            else drive(1'b1, 1'b0, 1'b0, 4'd3);
            e = sb.pop_front();
            total++;
            if ({Q0, TC0, RCN0} !== {e.q, e.tc, e.rcn}) begin
                bad++;
                $display("FAIL up_wrap%0d: got q=%h tc=%b rcn=%b want q=%h tc=%b rcn=%b", i, Q0, TC0, RCN0, e.q, e.tc, e.rcn);
            end
        end
        total++;
        if (Q0 !== 4'd0) begin
            bad++;
            $display("FAIL up_wrap_final: got q=%h want q=0", Q0);
        end
    endtask

    task automatic test_down_wrap;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 1'b1, 4'd1);
            else drive(1'b1, 1'b0, 1'b1, 4'd7);
            e = sb.pop_front();
            total++;
            if ({Q0, TC0, RCN0} !== {e.q, e.tc, e.rcn}) begin
                bad++;
                $display("FAIL down_wrap%0d: got q=%h tc=%b rcn=%b want q=%h tc=%b rcn=%b", i, Q0, TC0, RCN0, e.q, e.tc, e.rcn);
            end
        end
        CEN = 1'b1;
        #1;
        total++;
        if ({Q0, TC0, RCN0} !== {4'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL down_cen_off: got q=%h tc=%b rcn=%b want q=0 tc=1 rcn=1", Q0, TC0, RCN0);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd0);
        e = sb.pop_front();
        total++;
        if ({Q0, TC0, RCN0} !== {e.q, e.tc, e.rcn} || Q0 !== 4'd15) begin
            bad++;
            $display("FAIL down_wrap15: got q=%h tc=%b rcn=%b want q=%h tc=%b rcn=%b", Q0, TC0, RCN0, e.q, e.tc, e.rcn);
        end
    endtask

    task automatic test_load_priority;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 1'b0, 4'd15);
            else if (i == 1) drive(1'b0, 1'b0, 1'b0, 4'd9);
            else drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            e = sb.pop_front();
            total++;
            if ({Q0, TC0, RCN0} !== {e.q, e.tc, e.rcn}) begin
                bad++;
                $display("FAIL load_prio%0d: got q=%h tc=%b rcn=%b want q=%h tc=%b rcn=%b", i, Q0, TC0, RCN0, e.q, e.tc, e.rcn);
            end
        end
        total++;
        if (Q0 !== 4'd9) begin
            bad++;
            $display("FAIL load_prio_hold: got q=%h want q=9", Q0);
        end
    endtask

    task automatic test_cascade;
        exp_t       e;
        logic [7:0] c;
        @(negedge CP);
        PLN = 1'b1; CEN = 1'b1; UD = 1'b0;
        MRN = 1'b0;
        #1 MRN = 1'b1;
        m = 4'd0; c = 8'd0;
        total++;
        if ({Q1, Q0} !== 8'h00) begin
            bad++;
            $display("FAIL cascade_start: got %h want 00", {Q1, Q0});
        end
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0);
            c = c + 8'd1;
            e = sb.pop_front();
            total++;
            if ({Q1, Q0} !== c || {Q0, TC0, RCN0} !== {e.q, e.tc, e.rcn}) begin
                bad++;
                $display("FAIL cascade%0d: got %h%h tc0=%b rcn0=%b want %h tc0=%b rcn0=%b", i, Q1, Q0, TC0, RCN0, c, e.tc, e.rcn);
            end
        end
    endtask

    task automatic test_random;
        exp_t e;
        int   r[3];
        r[0] = $urandom_range(10, 60);
        r[1] = $urandom_range(70, 130);
        r[2] = $urandom_range(140, 190);
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            e = sb.pop_front();
            total++;
            if ({Q0, TC0, RCN0} !== {e.q, e.tc, e.rcn}) begin
                bad++;
                $display("FAIL random%0d: got q=%h tc=%b rcn=%b want q=%h tc=%b rcn=%b", i, Q0, TC0, RCN0, e.q, e.tc, e.rcn);
            end
            if (i == r[0] || i == r[1] || i == r[2]) begin
                #($urandom_range(1, 2)) MRN = 1'b0;
                #1;
                total++;
                if (Q0 !== 4'd0) begin
                    bad++;
                    $display("FAIL random_reset%0d: got q=%h want q=0", i, Q0);
                end
                MRN = 1'b1; m = 4'd0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_down_wrap;
        test_load_priority;
        test_cascade;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hc191_counter.md
HC191_COUNTER -- requirements
Module: hc191_counter

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, counter width in bits (legal 2..16).
REQ-002 SHALL provide port: CP  input  1  single clock; all state changes on rising edge except reset.
REQ-003 SHALL provide port: MRN  input  1  master reset, asynchronous, active-low.
REQ-004 SHALL provide port: PLN  input  1  parallel load enable, synchronous, active-low.
REQ-005 SHALL provide port: CEN  input  1  count enable, active-low.
REQ-006 SHALL provide port: UD  input  1  direction; 0 = up, 1 = down.
REQ-007 SHALL provide port: D  input  WIDTH  parallel load data.
REQ-008 SHALL provide port: Q  output  WIDTH  counter state, registered.
REQ-009 SHALL provide port: TC  output  1  terminal count, active-high.
REQ-010 SHALL provide port: RCN  output  1  ripple-carry enable to the next stage, active-low.
REQ-011 SHALL treat the interface as fixed: one clock (CP); reset MRN is asynchronous and active-low.

Function
REQ-012 SHALL apply this priority at each CP rising edge: PLN=0 load, else CEN=0 count, else hold.
REQ-013 SHALL on load set Q = D on that edge, ignoring CEN and UD.
REQ-014 SHALL on count with UD=0 set Q = Q+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-015 SHALL on count with UD=1 set Q = Q-1 modulo 2^WIDTH; 0 wraps to all-ones.
REQ-016 SHALL on hold (PLN=1, CEN=1) keep Q unchanged, whatever D or UD do.
REQ-017 SHALL give a latency of exactly one edge: new Q appears after the edge that samples the controls; no pipelining.
REQ-018 SHALL drive TC combinationally from Q and UD only (independent of CEN): TC=1 iff (UD=0 and Q=all-ones) or (UD=1 and Q=0).
REQ-019 SHALL drive RCN combinationally as RCN = NOT(TC AND NOT CEN); no clock term, no glitch path from CP.
REQ-020 SHALL use a change of UD at an edge for that edge's count direction; TC follows UD immediately.
REQ-021 SHALL give load priority over counting when PLN=0 and CEN=0 on the same edge, including at terminal count; wrap does not occur.
REQ-022 SHALL make cascading work: chaining RCN of stage n to CEN of stage n+1 on a shared CP forms a synchronous WIDTH*k-bit counter with no skipped or double counts.
REQ-023 SHALL keep every output free of X once MRN has been asserted, including when inputs are X while MRN=0.

Reset
REQ-024 SHALL while MRN=0 force Q = 0 immediately, without waiting for CP, and hold it regardless of PLN, CEN, UD, D.
REQ-025 SHALL while MRN=0 give TC = UD (Q=0 is terminal only when counting down) and RCN = NOT(UD AND NOT CEN).
REQ-026 SHALL on MRN deassertion change nothing until the next CP rising edge; the first edge with MRN=1 acts per REQ-012.
REQ-027 SHALL on MRN assertion mid-count or mid-load abort the operation; Q goes to 0 asynchronously and no partial value is visible.

Verification
REQ-028 SHALL cover reset: MRN=0 between edges, Q=5 -> Q=0 within the same time step; TC=0 with UD=0; after release, CEN=0, UD=0, 3 edges -> Q=3.
REQ-029 SHALL cover up-count wrap: WIDTH=4, load D=14, then CEN=0, UD=0 -> Q 14,15,0; TC=1 only while Q=15; RCN=0 only then.
REQ-030 SHALL cover down-count wrap: load D=1, UD=1, CEN=0 -> Q 1,0,15; TC=1 only while Q=0; toggling CEN=1 at Q=0 -> RCN=1, TC stays 1.
REQ-031 SHALL cover load priority: Q=15, UD=0, CEN=0, PLN=0, D=9 on one edge -> Q=9 (no wrap); PLN=1, CEN=1 for 4 edges -> Q stays 9.
REQ-032 SHALL cover cascade: two instances, RCN0 to CEN1, shared CP, from 0x00 count up 256 edges -> combined {Q1,Q0} steps 0x00..0xFF then 0x00, each value exactly once.
REQ-033 SHALL cover random regression: 200 edges of random PLN/CEN/UD/D with MRN pulsed low 3 times at random non-edge times -> Q matches a reference model every edge; no X after first reset.
